// File: rtl/ysyx_rf_wb_arb.sv
// Write-port controller for the single-write-port register file.
// Arbitrates EXU and LSU writebacks onto the RF write port. LSU has fixed
// priority over EXU. Tracks in-flight loads in a pending scoreboard and
// reports read hazards to decode.
//
// Handshake: a request transfers on a rising edge where valid && ready.
// Ready may depend on valid. A source whose request is not accepted keeps
// it (and its payload) stable until it is accepted. Nothing is buffered here.
module ysyx_rf_wb_arb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int MAX_LD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              ld_issue_valid,
  output logic              ld_issue_ready,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        ld_outstanding
);

  localparam int         NREG    = 1 << ADDR_W;
  localparam logic [2:0] MAX_CNT = 3'(MAX_LD);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;
  logic              issue_acc;
  logic              lsu_acc;
  logic              wb_go;
  logic              wb_wr;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  assign ld_outstanding = cnt;

  // The EXU is held off a register with an older load still pending (WAW).
  assign lsu_ready      = lsu_valid;
  assign exu_ready      = exu_valid & ~lsu_valid & ~pend[exu_rd];
  assign ld_issue_ready = (cnt < MAX_CNT) & ~pend[ld_issue_rd] &
                          ~(rf_wr_en & (rf_waddr == ld_issue_rd));

  assign issue_acc = ld_issue_valid & ld_issue_ready;
  assign lsu_acc   = lsu_valid;

  // The in-flight write is not visible to an RF read until the next cycle.
  assign busy1 = (raddr1 != '0) & (pend[raddr1] | (rf_wr_en & (rf_waddr == raddr1)));
  assign busy2 = (raddr2 != '0) & (pend[raddr2] | (rf_wr_en & (rf_waddr == raddr2)));

  // Select the writeback winner for this cycle; x0 is consumed without a write.
  always_comb begin
    wb_go   = 1'b0;
    wb_rd   = exu_rd;
    wb_data = exu_data;
    if (lsu_acc) begin
      wb_go   = 1'b1;
      wb_rd   = lsu_rd;
      wb_data = lsu_data;
    end else if (exu_ready) begin
      wb_go   = 1'b1;
    end
    wb_wr = wb_go & (wb_rd != '0);
  end

  // Scoreboard update: a return clears its bit, a new load to rd!=0 sets one.
  always_comb begin
    pend_nxt = pend;
    if (lsu_acc) pend_nxt[lsu_rd] = 1'b0;
    if (issue_acc && (ld_issue_rd != '0)) pend_nxt[ld_issue_rd] = 1'b1;
  end

  // Outstanding-load count; a return with nothing outstanding holds at zero.
  always_comb begin
    cnt_nxt = cnt;
    case ({issue_acc, lsu_acc})
      2'b10:   cnt_nxt = cnt + 3'd1;
      2'b01:   cnt_nxt = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Scoreboard and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      cnt  <= 3'd0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Registered RF write port; address/data hold when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wr_en <= wb_wr;
      if (wb_wr) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

endmodule
